// File: rtl/ravenoc_pkg.sv
// Shared router definitions: default link geometry, flit-type encoding and
// the credit-counter width derived from the downstream buffer depth.
package ravenoc_pkg;

  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned FLIT_W   = 34;
  localparam int unsigned CREDITS  = 2;
  localparam int unsigned CREDIT_W = $clog2(CREDITS + 1);

  // Flit type lives in the two most significant bits of every flit.
  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_HEAD_TAIL = 2'b10,
    FLIT_TAIL      = 2'b11
  } flit_type_t;

  // Extracts the flit type from a default-width flit.
  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[FLIT_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/vc_output_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. Grants the first set
// request found searching upward from ptr, wrapping at N. One-hot output.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: router output stage. Picks one head flit per cycle from
// the per-VC buffers with a credit-gated round-robin arbiter and registers
// it onto the output link. Returned credits track downstream buffer space.
// Optional packet lock (a HEAD holds the link until its TAIL) is enabled by
// defining VC_ARB_PKT_LOCK_EN; otherwise flits of different VCs interleave.
module vc_output_arbiter #(
  parameter int unsigned NUM_VC  = ravenoc_pkg::NUM_VC,
  parameter int unsigned FLIT_W  = ravenoc_pkg::FLIT_W,
  parameter int unsigned CREDITS = ravenoc_pkg::CREDITS
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [NUM_VC*FLIT_W-1:0]    fdata_i,
  input  logic [NUM_VC-1:0]           valid_i,
  output logic [NUM_VC-1:0]           ready_o,
  output logic [FLIT_W-1:0]           fdata_o,
  output logic [$clog2(NUM_VC)-1:0]   vc_id_o,
  output logic                        valid_o,
  input  logic [NUM_VC-1:0]           credit_i,
  output logic                        credit_err_o
);

  import ravenoc_pkg::*;

  localparam int unsigned VC_W  = $clog2(NUM_VC);
  localparam int unsigned CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

  logic [CNT_W-1:0]  credit [NUM_VC];
  logic [VC_W-1:0]   rr_ptr;
  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] gnt;
  logic              any_gnt;
  logic [VC_W-1:0]   gnt_idx;
  logic [FLIT_W-1:0] gnt_flit;
  logic [VC_W-1:0]   next_ptr;

`ifdef VC_ARB_PKT_LOCK_EN
  logic              lock;
  logic [VC_W-1:0]   lock_vc;
  flit_type_t        gnt_type;
`endif

  // A VC may compete when it has a flit and downstream space; a held lock
  // narrows the field to the locked VC only.
  always_comb begin
    elig = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      elig[v] = valid_i[v] && (credit[v] != '0);
`ifdef VC_ARB_PKT_LOCK_EN
      if (lock && (lock_vc != VC_W'(v))) begin
        elig[v] = 1'b0;
      end
`endif
    end
  end

  // No grants are offered while reset is held.
  always_comb begin
    req = arst ? '0 : elig;
  end

  rr_arbiter #(
    .N     (NUM_VC),
    .PTR_W (VC_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign ready_o = gnt;
  assign any_gnt = |gnt;

  // Convert the one-hot grant into an index and select the granted flit.
  always_comb begin
    gnt_idx  = '0;
    gnt_flit = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (gnt[v]) begin
        gnt_idx  = VC_W'(v);
        gnt_flit = fdata_i[v*FLIT_W +: FLIT_W];
      end
    end
  end

  // Pointer moves just past the granted VC, wrapping at NUM_VC.
  always_comb begin
    if (gnt_idx == VC_W'(NUM_VC - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = gnt_idx + VC_W'(1);
    end
  end

`ifdef VC_ARB_PKT_LOCK_EN
  assign gnt_type = flit_type_t'(gnt_flit[FLIT_W-1 -: 2]);
`endif

  // Per-VC credit counters: a send consumes, a return refunds, both cancel.
  // A return to a full counter is held off and flagged as sticky error.
  always_ff @(posedge clk) begin
    if (arst) begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        credit[v] <= CNT_FULL;
      end
      credit_err_o <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        unique case ({gnt[v], credit_i[v]})
          2'b10: credit[v] <= credit[v] - CNT_W'(1);
          2'b01: begin
            if (credit[v] == CNT_FULL) begin
              credit_err_o <= 1'b1;
            end else begin
              credit[v] <= credit[v] + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Round-robin pointer and packet lock state.
  // Releasing the lock on a TAIL/HEAD_TAIL from lock_vc needs no special
  // pointer handling: only lock_vc can be granted then, so next_ptr already
  // equals lock_vc + 1.
  always_ff @(posedge clk) begin
    if (arst) begin
      rr_ptr  <= '0;
`ifdef VC_ARB_PKT_LOCK_EN
      lock    <= 1'b0;
      lock_vc <= '0;
`endif
    end else if (any_gnt) begin
      rr_ptr <= next_ptr;
`ifdef VC_ARB_PKT_LOCK_EN
      if (gnt_type == FLIT_HEAD) begin
        lock    <= 1'b1;
        lock_vc <= gnt_idx;
      end else if ((gnt_type == FLIT_TAIL) || (gnt_type == FLIT_HEAD_TAIL)) begin
        lock    <= 1'b0;
      end
`endif
    end
  end

  // Link register: data and VC id hold when idle, valid marks a new flit.
  always_ff @(posedge clk) begin
    if (arst) begin
      valid_o <= 1'b0;
      fdata_o <= '0;
      vc_id_o <= '0;
    end else begin
      valid_o <= any_gnt;
      if (any_gnt) begin
        fdata_o <= gnt_flit;
        vc_id_o <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed bench for vc_output_arbiter: a per-cycle vector table plus
// hand-written sequences for the packet-lock and mid-packet reset cases.
module tb_vc_output_arbiter;

  localparam int unsigned NV = 4;
  localparam int unsigned FW = 34;

  logic              clk = 1'b0;
  logic              arst;
  logic [NV*FW-1:0]  fdata_i;
  logic [NV-1:0]     valid_i;
  logic [NV-1:0]     ready_o;
  logic [FW-1:0]     fdata_o;
  logic [1:0]        vc_id_o;
  logic              valid_o;
  logic [NV-1:0]     credit_i;
  logic              credit_err_o;

  logic [FW-1:0]     fl [NV];

  int n_vec   = 0;
  int n_check = 0;
  int n_miss  = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] credit;
    logic [3:0] ready;
    logic       vo;
    logic [1:0] vc;
    logic       err;
  } vec_t;

  vec_t tbl [25];

  vc_output_arbiter #(
    .NUM_VC  (4),
    .FLIT_W  (34),
    .CREDITS (2)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .fdata_i      (fdata_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .fdata_o      (fdata_o),
    .vc_id_o      (vc_id_o),
    .valid_o      (valid_o),
    .credit_i     (credit_i),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h expected %h", name, n_vec, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check ready before the edge, check the
  // registered outputs just after it.
  task automatic step(input logic rst, input logic [3:0] valid, input logic [3:0] credit,
                      input logic [3:0] ready, input logic vo, input logic [1:0] vc,
                      input logic err);
    @(negedge clk);
    arst     = rst;
    valid_i  = valid;
    credit_i = credit;
    for (int v = 0; v < NV; v++) fdata_i[v*FW +: FW] = fl[v];
    #1;
    chk("ready_o", 64'(ready_o), 64'(ready));
    @(posedge clk);
    #1;
    chk("valid_o", 64'(valid_o), 64'(vo));
    chk("vc_id_o", 64'(vc_id_o), 64'(vc));
    chk("credit_err_o", 64'(credit_err_o), 64'(err));
    if (rst) chk("fdata_o_rst", 64'(fdata_o), 64'(0));
    else if (vo) chk("fdata_o", 64'(fdata_o), 64'(fl[vc]));
    n_vec++;
  endtask

  task automatic set_ht_flits();
    for (int v = 0; v < NV; v++) fl[v] = {2'b10, 32'hC0DE_0000 + 32'(v)};
  endtask

  initial begin
    arst = 1'b1; valid_i = '0; credit_i = '0; fdata_i = '0;
    set_ht_flits();

    // First flit after reset: one-cycle latency to the link.
    fl[0] = 34'h0_0000_0011;
    step(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
    chk("first_flit", 64'(fdata_o), 64'h11);
    set_ht_flits();

    //            rst  valid    credit   ready    vo   vc    err
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1};
    tbl[19] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd1, 1'b1};
    tbl[20] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[21] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[22] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[23] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0};
    tbl[24] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].credit, tbl[i].ready,
           tbl[i].vo, tbl[i].vc, tbl[i].err);
    end

    // Packet on VC1 competing with VC0/VC3; credits mirror the grants.
    set_ht_flits();
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    fl[1] = {2'b00, 32'h1111_0001};
    step(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    fl[1] = {2'b01, 32'h1111_0002};
`ifdef VC_ARB_PKT_LOCK_EN
    step(1'b0, 4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    fl[1] = {2'b11, 32'h1111_0003};
    step(1'b0, 4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    step(1'b0, 4'b1011, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);
    step(1'b0, 4'b1011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
`else
    step(1'b0, 4'b1011, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);
    step(1'b0, 4'b1011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
    step(1'b0, 4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
    fl[1] = {2'b11, 32'h1111_0003};
    step(1'b0, 4'b1011, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);
`endif

    // Reset mid-packet: lock and credits restored, VC0 wins first.
    set_ht_flits();
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    fl[1] = {2'b00, 32'h2222_0001};
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    fl[1] = {2'b01, 32'h2222_0002};
    step(1'b1, 4'b0011, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
